// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default PC values,
// the fetch control state encoding and the layout of a fetch queue entry.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'h0000_0004;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_next;
    } queue_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched words. Flush empties it in one
// cycle. Pointers wrap naturally because DEPTH is a power of two.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observed while the entry is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign empty = (count_r == {CW{1'b0}});
    assign full  = (count_r == CW'(DEPTH));
    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: generates the PC, keeps one request in flight to
// instruction memory, buffers returned words and hands {instr, PC+step} to
// decode. Redirects flush the queue and squash any in-flight fetch.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] PC_STEP     = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW:0] OCC_ONE = {{CW{1'b0}}, 1'b1};

    fetch_state_e  state_r;
    fetch_state_e  state_next_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   fetch_pc_next_s;
    logic          req_next_s;
    logic [31:0]   addr_next_s;

    logic          ack_s;
    logic          push_s;
    logic          pop_s;
    logic          q_full_s;
    logic          q_empty_s;
    queue_entry_t  q_head_s;
    queue_entry_t  push_entry_s;
    logic [CW-1:0] q_count_s;
    logic [CW:0]   occ_next_s;
    logic          room_s;
    logic [31:0]   seq_addr_s;

    // An ack only counts while a request is actually outstanding.
    assign ack_s      = imem_req && imem_ack;
    assign seq_addr_s = imem_addr + PC_STEP;
    assign pop_s      = !q_empty_s && id_ready;
    assign push_s     = ack_s && (state_r == FETCH) && !branch_taken;

    assign push_entry_s.instr   = imem_rdata;
    assign push_entry_s.pc_next = seq_addr_s;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (branch_taken),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .head      (q_head_s),
        .count     (q_count_s)
    );

    // Queue occupancy after this edge, used to decide whether to issue.
    always_comb begin
        occ_next_s = {1'b0, q_count_s};
        if (branch_taken) begin
            occ_next_s = {(CW+1){1'b0}};
        end else if (push_s && !pop_s) begin
            occ_next_s = {1'b0, q_count_s} + OCC_ONE;
        end else if (!push_s && pop_s) begin
            occ_next_s = {1'b0, q_count_s} - OCC_ONE;
        end else begin
            occ_next_s = {1'b0, q_count_s};
        end
        room_s = (occ_next_s < (CW+1)'(QUEUE_DEPTH));
    end

    // Next fetch state, PC and memory request; redirect overrides all else.
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        req_next_s      = imem_req;
        addr_next_s     = imem_addr;
        if (branch_taken) begin
            fetch_pc_next_s = branch_target;
            if (imem_req && !imem_ack) begin
                state_next_s = DROP;
            end else begin
                state_next_s = FETCH;
                req_next_s   = 1'b1;
                addr_next_s  = branch_target;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (imem_req && !imem_ack) begin
                        state_next_s = FETCH;
                    end else begin
                        if (ack_s) begin
                            fetch_pc_next_s = seq_addr_s;
                        end else begin
                            fetch_pc_next_s = fetch_pc_r;
                        end
                        if (room_s) begin
                            req_next_s  = 1'b1;
                            addr_next_s = ack_s ? seq_addr_s : fetch_pc_r;
                        end else begin
                            req_next_s   = 1'b0;
                            state_next_s = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (pop_s || !q_full_s) begin
                        state_next_s = FETCH;
                        req_next_s   = 1'b1;
                        addr_next_s  = fetch_pc_r;
                    end else begin
                        req_next_s = 1'b0;
                    end
                end
                DROP: begin
                    // Squashed data is discarded; restart at the redirect target.
                    if (ack_s) begin
                        state_next_s = FETCH;
                        req_next_s   = 1'b1;
                        addr_next_s  = fetch_pc_r;
                    end else begin
                        state_next_s = DROP;
                    end
                end
                default: begin
                    state_next_s = FETCH;
                    req_next_s   = 1'b0;
                    addr_next_s  = fetch_pc_r;
                end
            endcase
        end
    end

    // Fetch control registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= FETCH;
            fetch_pc_r <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            imem_req   <= req_next_s;
            imem_addr  <= addr_next_s;
        end
    end

    assign id_valid       = !q_empty_s;
    assign id_instruction = q_empty_s ? 32'h0000_0000 : q_head_s.instr;
    assign id_pc          = q_empty_s ? 32'h0000_0000 : q_head_s.pc_next;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a memory model with programmable ack latency,
// directed redirect/backpressure scenarios and a scoreboard on the decode port.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] req_log[$];
    int          check_cnt = 0;
    int          err_cnt   = 0;
    int          xfer_cnt  = 0;
    int          latency   = 0;
    int          wait_cnt  = 0;
    logic [31:0] held_addr = 32'h0;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instruction (id_instruction),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        check_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{mem_word(base + 32'(4 * i)), base + 32'(4 * i + 4)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_test(input int lat);
        rst = 1'b1;
        id_ready = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        latency = lat;
        exp_q.delete();
        req_log.delete();
        xfer_cnt = 0;
    endtask

    // Memory model: acks after 'latency' wait cycles, logs each new request,
    // and checks the address stays stable while a request is pending.
    always @(negedge clk) begin
        if (rst || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else begin
            if (imem_ack) wait_cnt = 0;
            if (wait_cnt == 0) begin
                req_log.push_back(imem_addr);
                held_addr = imem_addr;
            end else begin
                check("addr_hold", imem_addr, held_addr);
            end
            if (wait_cnt >= latency) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    // Scoreboard monitor on the decode handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (id_valid && id_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    err_cnt++;
                    $display("FAIL xfer_unexpected: got pc %h, expected no transfer", id_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("xfer_instr", id_instruction, mon_e.instr);
                    check("xfer_pc", id_pc, mon_e.pc);
                end
            end else if (!id_valid) begin
                check("idle_instr", id_instruction, 32'h0);
                check("idle_pc", id_pc, 32'h0);
            end
        end
    end

    initial begin
        int found_80;

        // Test 1: reset state, then zero-wait streaming at one per cycle.
        start_test(0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_instr", id_instruction, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        id_ready = 1'b1;
        push_exp(32'h0, 16);
        rst = 1'b0;
        tick();
        check("t1_first_req", 32'(imem_req), 32'd1);
        check("t1_first_addr", imem_addr, 32'h0);
        check("t1_first_valid", 32'(id_valid), 32'd0);
        repeat (8) tick();
        check("t1_xfers", 32'(xfer_cnt), 32'd7);

        // Test 2: decode stalled, queue fills with two entries then resumes.
        start_test(0);
        push_exp(32'h0, 16);
        rst = 1'b0;
        repeat (8) tick();
        check("t2_captured", 32'(req_log.size()), 32'd2);
        check("t2_req_low", 32'(imem_req), 32'd0);
        check("t2_valid", 32'(id_valid), 32'd1);
        check("t2_head_pc", id_pc, 32'h4);
        id_ready = 1'b1;
        repeat (6) tick();
        check("t2_resume_addr", req_log[2], 32'h8);
        check("t2_xfers", 32'(xfer_cnt), 32'd6);

        // Test 3: redirect in the first cycle of a 3-wait request to 0x20.
        start_test(3);
        id_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h20;
        rst = 1'b0;
        tick();
        check("t3_req", 32'(imem_req), 32'd1);
        check("t3_addr0", imem_addr, 32'h20);
        branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        check("t3_addr1", imem_addr, 32'h20);
        tick();
        check("t3_addr2", imem_addr, 32'h20);
        tick();
        check("t3_addr3", imem_addr, 32'h20);
        tick();
        check("t3_new_req", 32'(imem_req), 32'd1);
        check("t3_new_addr", imem_addr, 32'h100);
        push_exp(32'h100, 4);
        repeat (16) tick();
        check("t3_xfers", 32'(xfer_cnt), 32'd3);
        check("t3_log1", req_log[1], 32'h100);

        // Test 4: redirect coincident with the ack for 0x10, one entry queued.
        start_test(0);
        branch_taken = 1'b1;
        branch_target = 32'h0C;
        rst = 1'b0;
        tick();
        branch_taken = 1'b0;
        tick();
        check("t4_one_entry", 32'(id_valid), 32'd1);
        check("t4_addr10", imem_addr, 32'h10);
        branch_taken = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        check("t4_flushed", 32'(id_valid), 32'd0);
        check("t4_addr40", imem_addr, 32'h40);
        check("t4_req", 32'(imem_req), 32'd1);
        id_ready = 1'b1;
        push_exp(32'h40, 8);
        repeat (4) tick();
        check("t4_xfers", 32'(xfer_cnt), 32'd3);

        // Test 5: two redirects while one request stays outstanding.
        start_test(3);
        id_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h20;
        rst = 1'b0;
        tick();
        branch_target = 32'h80;
        tick();
        branch_target = 32'hC0;
        tick();
        branch_taken = 1'b0;
        check("t5_addr_held", imem_addr, 32'h20);
        push_exp(32'hC0, 4);
        tick();
        tick();
        check("t5_new_addr", imem_addr, 32'hC0);
        repeat (16) tick();
        check("t5_log_size", 32'(req_log.size()), 32'd5);
        check("t5_log1", req_log[1], 32'hC0);
        found_80 = 0;
        foreach (req_log[i]) if (req_log[i] == 32'h80) found_80++;
        check("t5_no_80", 32'(found_80), 32'd0);
        check("t5_xfers", 32'(xfer_cnt), 32'd3);

        // Test 6: asynchronous reset during a request to 0x24.
        start_test(0);
        branch_taken = 1'b1;
        branch_target = 32'h20;
        rst = 1'b0;
        tick();
        branch_taken = 1'b0;
        tick();
        check("t6_pre_addr", imem_addr, 32'h24);
        check("t6_pre_valid", 32'(id_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_req", 32'(imem_req), 32'd0);
        check("t6_async_valid", 32'(id_valid), 32'd0);
        check("t6_async_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        exp_q.delete();
        req_log.delete();
        rst = 1'b0;
        tick();
        check("t6_post_req", 32'(imem_req), 32'd1);
        check("t6_post_addr", imem_addr, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage. It generates the PC, issues single-outstanding requests to instruction memory and buffers fetched words in a small queue. It hands {instruction, PC+4} to the decode stage over a valid/ready handshake. Branch redirects from later stages flush the queue and squash any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
QUEUE_DEPTH, 2, fetch queue entries (power of two, >=2)
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  fetch address; stable while imem_req high
imem_ack  input  1  single-cycle pulse, imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
branch_taken  input  1  redirect strobe from execute
branch_target  input  32  redirect address, sampled when branch_taken=1
id_valid  output  1  queue head valid toward decode
id_ready  input  1  decode accepts head this cycle
id_instruction  output  32  head instruction; 0 when id_valid=0
id_pc  output  32  head instruction address + PC_STEP; 0 when id_valid=0

Behaviour:
- Reset (async): imem_req=0, imem_addr=RESET_PC, queue empty, id_valid=0, id_instruction=0, id_pc=0, fetch_pc=RESET_PC, state=FETCH.
- All outputs are registered or come from queue state only. There is no combinational path from input to output.
- Memory protocol: one request outstanding at most. Once imem_req rises, imem_req and imem_addr hold until the cycle imem_ack=1. Ack may arrive in the first cycle of the request (zero-wait). imem_ack while imem_req=0 is ignored.
- Issue rule: the request is raised at the next edge when the state is FETCH and the post-edge queue occupancy (including any push or pop this cycle) is below QUEUE_DEPTH. After reset release, imem_req=1 with addr=RESET_PC on the first edge.
- Throughput: with zero-wait memory and id_ready=1, the block delivers one instruction per cycle with back-to-back imem_req.
- Ack in FETCH: push {imem_rdata, imem_addr+PC_STEP} and set fetch_pc=imem_addr+PC_STEP. id_valid rises the next cycle if the queue was empty.
- States:
  - FETCH: normal operation.
  - HOLD: queue full, imem_req=0. Move to FETCH when a pop frees a slot.
  - DROP: a redirect occurred while a request was outstanding. Keep imem_req/imem_addr unchanged, discard data on ack, issue to fetch_pc (the target) at the ack edge, then move to FETCH.
- Redirect (branch_taken=1) has priority over everything else:
  - Queue flushed; id_valid=0 the next cycle.
  - fetch_pc=branch_target.
  - If a request is outstanding with no ack this cycle, go to DROP.
  - If ack arrives in the same cycle, discard the data; next request goes to branch_target.
  - If no request is outstanding, the next request goes to branch_target.
- A redirect in DROP updates fetch_pc to the newest target and stays in DROP.
- Redirect with a simultaneous id_valid&id_ready: the transfer counts as completed; the flush still clears the remaining entries.
- Queue: FIFO, pointers wrap modulo QUEUE_DEPTH.
  - Push and pop in the same cycle are both honoured, occupancy unchanged.
  - Pop on empty is impossible (id_valid=0).
  - Push on full is impossible by the issue rule.
- PC arithmetic: 32-bit, wraps at 2^32 without a flag.
- Reset asserted mid-request: imem_req drops immediately (asynchronous) and all state clears. Memory must tolerate an abandoned request.

Decomposition:
- Shared package holds:
  - RESET_PC default
  - PC_STEP
  - fetch state enum {FETCH, HOLD, DROP}
  - queue entry struct {instr[31:0], pc_next[31:0]}
- One sub-module: fetch_queue. It is a synchronous FIFO with push, pop, flush, full, empty and head outputs, parameterised by QUEUE_DEPTH and width 64.

Test Plan:
- Reset, then release; memory zero-wait, id_ready=1 -> imem_req=1, addr=0 on first edge. Decode sees {mem[0], pc 4}, {mem[4], pc 8}, {mem[8], pc 12} on consecutive cycles.
- id_ready=0 for 6 cycles, zero-wait memory -> exactly 2 entries captured (pcs 4, 8), imem_req low, state HOLD. After id_ready=1 the stream resumes with addr 8, no word lost or duplicated.
- Ack latency 3, branch_taken with target 0x100 in cycle 1 of the request to addr 0x20 -> imem_addr stays 0x20 until ack. Data from 0x20 is never presented. Next request is addr 0x100; first delivered is {mem[0x100], pc 0x104}.
- branch_taken with target 0x40 in the same cycle as ack for addr 0x10, queue holding 1 entry -> queue flushed, id_valid=0 the next cycle. The 0x10 word is discarded; next imem_addr=0x40.
- Two redirects (0x80, then 0xC0) during one outstanding DROP -> after ack, single request to 0xC0. No fetch of 0x80.
- rst asserted asynchronously while imem_req=1 with addr 0x24 -> imem_req=0 and id_valid=0 before the next edge. After release, imem_addr=RESET_PC.
